// File: rtl/md_pkg.sv
// Shared MD-unit definitions: op codes, FSM states and default latencies.
package md_pkg;

  // 3-bit MD op codes shared with the controller and hazard unit.
  // Codes 3'd0 and 3'd7 are unused and behave as no-ops.
  typedef enum logic [2:0] {
    MD_mult  = 3'd1,
    MD_multu = 3'd2,
    MD_div   = 3'd3,
    MD_divu  = 3'd4,
    MD_mthi  = 3'd5,
    MD_mtlo  = 3'd6
  } md_op_e;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_RUN  = 1'b1
  } md_state_e;

  localparam int unsigned MD_MULT_CYCLES = 5;
  localparam int unsigned MD_DIV_CYCLES  = 10;

  // True for ops that occupy the unit for several cycles.
  function automatic logic md_is_long(input logic [2:0] op);
    return (op == MD_mult) || (op == MD_multu) || (op == MD_div) || (op == MD_divu);
  endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational MD datapath: latched op/A/B -> {hi_res, lo_res} plus write enable.
module md_calc
  import md_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi_res,
  output logic [31:0] lo_res,
  output logic        res_we
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        is_sdiv;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] dvd;
  logic [31:0] dvs;
  logic [31:0] q_mag;
  logic [31:0] r_mag;

  // Signed divide works on magnitudes so the INT_MIN / -1 case wraps cleanly
  // to 0x80000000 instead of hitting an overflowing signed division.
  always_comb begin
    prod_s  = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    prod_u  = {32'b0, a} * {32'b0, b};
    is_sdiv = (op == MD_div);
    a_neg   = is_sdiv && a[31];
    b_neg   = is_sdiv && b[31];
    dvd     = a_neg ? (32'd0 - a) : a;
    dvs     = b_neg ? (32'd0 - b) : b;
    if (dvs == '0) begin
      q_mag = '0;
      r_mag = '0;
    end else begin
      q_mag = dvd / dvs;
      r_mag = dvd % dvs;
    end
  end

  // Select the result for the latched op; divide by zero leaves HI/LO alone.
  always_comb begin
    hi_res = '0;
    lo_res = '0;
    res_we = 1'b0;
    case (op)
      MD_mult: begin
        {hi_res, lo_res} = prod_s;
        res_we = 1'b1;
      end
      MD_multu: begin
        {hi_res, lo_res} = prod_u;
        res_we = 1'b1;
      end
      MD_div, MD_divu: begin
        lo_res = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
        hi_res = a_neg ? (32'd0 - r_mag) : r_mag;
        res_we = (b != '0);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers and mthi/mtlo support.
module md_unit
  import md_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES,
  parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES,
  parameter int unsigned CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  MDctrE,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        flush,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  md_state_e        state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       op_q;
  logic [31:0]      a_q, b_q;
  logic             latch_en;
  logic [31:0]      hi_n, lo_n;
  logic [31:0]      hi_res, lo_res;
  logic             res_we;

  md_calc u_calc (
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .hi_res (hi_res),
    .lo_res (lo_res),
    .res_we (res_we)
  );

  // State, counter, operand latches and HI/LO registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= MD_IDLE;
      cnt   <= '0;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      HI    <= '0;
      LO    <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      HI    <= hi_n;
      LO    <= lo_n;
      if (latch_en) begin
        op_q <= MDctrE;
        a_q  <= A;
        b_q  <= B;
      end
    end
  end

  // Next-state, counter and HI/LO update; flush beats both start and completion.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    latch_en = 1'b0;
    hi_n     = HI;
    lo_n     = LO;
    case (state)
      MD_IDLE: begin
        if (start && !flush) begin
          if (md_is_long(MDctrE)) begin
            latch_en = 1'b1;
            state_n  = MD_RUN;
            if (MDctrE == MD_mult || MDctrE == MD_multu)
              cnt_n = CNT_W'(MULT_CYCLES - 1);
            else
              cnt_n = CNT_W'(DIV_CYCLES - 1);
          end else if (MDctrE == MD_mthi) begin
            hi_n = A;
          end else if (MDctrE == MD_mtlo) begin
            lo_n = A;
          end
        end
      end
      MD_RUN: begin
        if (flush) begin
          state_n = MD_IDLE;
          cnt_n   = '0;
        end else if (cnt == '0) begin
          state_n = MD_IDLE;
          if (res_we) begin
            hi_n = hi_res;
            lo_n = lo_res;
          end
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      default: state_n = MD_IDLE;
    endcase
  end

  assign busy = (state == MD_RUN);

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed spec cases plus randomized traffic
// against a completion-time model computed with 64-bit arithmetic.
module tb_md_unit;
  import md_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  MDctrE = '0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        flush = 1'b0;
  logic        busy;
  logic [31:0] HI, LO;

  int vectors = 0;
  int miscompares = 0;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .MDctrE(MDctrE),
    .A(A), .B(B), .flush(flush), .busy(busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  // Model: architectural HI/LO, plus the edge index at which a pending op commits.
  logic [31:0] m_hi = '0, m_lo = '0;
  logic        m_inflight = 1'b0;
  int          m_edge = 0;
  int          m_commit_edge = 0;
  logic [31:0] p_hi, p_lo;
  logic        p_we;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [64:0] model_res(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint      x, y, q, r;
    logic [63:0] u;
    model_res = '0;
    case (op)
      MD_mult: begin
        x = longint'($signed(a)); y = longint'($signed(b)); q = x * y;
        model_res = {1'b1, q[63:0]};
      end
      MD_multu: begin
        u = {32'b0, a} * {32'b0, b};
        model_res = {1'b1, u};
      end
      MD_div: if (b != 0) begin
        x = longint'($signed(a)); y = longint'($signed(b));
        q = x / y; r = x % y;
        model_res = {1'b1, r[31:0], q[31:0]};
      end
      MD_divu: if (b != 0) model_res = {1'b1, a % b, a / b};
      default: ;
    endcase
  endfunction

  // One clock: drive inputs, advance the model to the next edge, compare after it.
  task automatic step(input logic s, input logic [2:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic f);
    logic [64:0] res;
    start = s; MDctrE = op; A = a; B = b; flush = f;
    m_edge++;
    if (m_inflight && s) begin
      miscompares++;
      $display("FAIL protocol: start while busy (t=%0t)", $time);
    end
    if (m_inflight) begin
      if (f) m_inflight = 1'b0;
      else if (m_edge == m_commit_edge) begin
        m_inflight = 1'b0;
        if (p_we) begin m_hi = p_hi; m_lo = p_lo; end
      end
    end else if (s && !f) begin
      if (md_is_long(op)) begin
        res = model_res(op, a, b);
        {p_we, p_hi, p_lo} = res;
        m_inflight = 1'b1;
        m_commit_edge = m_edge +
          ((op == MD_mult || op == MD_multu) ? 5 : 10);
      end else if (op == MD_mthi) m_hi = a;
      else if (op == MD_mtlo) m_lo = a;
    end
    @(posedge clk); #1;
    check("busy", {31'b0, busy}, {31'b0, m_inflight});
    check("HI", HI, m_hi);
    check("LO", LO, m_lo);
  endtask

  task automatic idle();
    step(1'b0, '0, $urandom, $urandom, 1'b0);
  endtask

  // Start a long op and wait (bounded) for busy to drop; returns busy cycle count.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int ncyc);
    ncyc = 0;
    step(1'b1, op, a, b, 1'b0);
    while (busy && ncyc < 40) begin
      ncyc++;
      idle();
    end
    if (busy) begin
      miscompares++;
      $display("FAIL timeout: busy still high after 40 cycles");
    end
  endtask

  int n;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_HI", HI, 32'd0);
    check("reset_LO", LO, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    run_op(MD_mult, 32'hFFFF_FFFE, 32'd3, n);
    check("mult_cycles", n, 32'd5);
    check("mult_HI", HI, 32'hFFFF_FFFF);
    check("mult_LO", LO, 32'hFFFF_FFFA);

    run_op(MD_multu, 32'hFFFF_FFFF, 32'd2, n);
    check("multu_HI", HI, 32'd1);
    check("multu_LO", LO, 32'hFFFF_FFFE);

    run_op(MD_div, 32'hFFFF_FFF9, 32'd2, n);
    check("div_cycles", n, 32'd10);
    check("div_LO", LO, 32'hFFFF_FFFD);
    check("div_HI", HI, 32'hFFFF_FFFF);

    step(1'b1, MD_mthi, 32'h11, '0, 1'b0);
    step(1'b1, MD_mtlo, 32'h22, '0, 1'b0);
    run_op(MD_divu, 32'h1234, 32'd0, n);
    check("div0_cycles", n, 32'd10);
    check("div0_HI", HI, 32'h11);
    check("div0_LO", LO, 32'h22);

    run_op(MD_div, 32'h8000_0000, 32'hFFFF_FFFF, n);
    check("ovf_LO", LO, 32'h8000_0000);
    check("ovf_HI", HI, 32'd0);

    step(1'b1, MD_mtlo, 32'hDEAD_BEEF, '0, 1'b0);
    check("mtlo_busy", {31'b0, busy}, 32'd0);
    check("mtlo_LO", LO, 32'hDEAD_BEEF);
    step(1'b1, MD_mthi, 32'd5, '0, 1'b0);
    check("mthi_HI", HI, 32'd5);

    // Flush on the fourth busy cycle.
    step(1'b1, MD_div, 32'd100, 32'd7, 1'b0);
    repeat (3) idle();
    step(1'b0, '0, '0, '0, 1'b1);
    check("flush4_busy", {31'b0, busy}, 32'd0);
    check("flush4_HI", HI, 32'd5);
    check("flush4_LO", LO, 32'hDEAD_BEEF);

    // Flush on the final busy cycle: completion loses.
    step(1'b1, MD_divu, 32'd100, 32'd7, 1'b0);
    repeat (9) idle();
    check("last_busy", {31'b0, busy}, 32'd1);
    step(1'b0, '0, '0, '0, 1'b1);
    check("flushlast_busy", {31'b0, busy}, 32'd0);
    check("flushlast_HI", HI, 32'd5);
    check("flushlast_LO", LO, 32'hDEAD_BEEF);

    // Start together with flush, and invalid op codes, do nothing.
    step(1'b1, MD_mthi, 32'h7777, '0, 1'b1);
    check("startflush_HI", HI, 32'd5);
    step(1'b1, 3'd0, 32'h1, 32'h1, 1'b0);
    step(1'b1, 3'd7, 32'h1, 32'h1, 1'b0);
    check("invalid_busy", {31'b0, busy}, 32'd0);

    // Asynchronous reset between edges in the middle of a mult.
    step(1'b1, MD_multu, 32'd9, 32'd9, 1'b0);
    idle(); idle();
    start = 1'b0; flush = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("areset_busy", {31'b0, busy}, 32'd0);
    check("areset_HI", HI, 32'd0);
    check("areset_LO", LO, 32'd0);
    m_hi = '0; m_lo = '0; m_inflight = 1'b0;
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    check("post_reset_LO", LO, 32'd0);
    run_op(MD_multu, 32'd3, 32'd4, n);
    check("post_reset_multu_LO", LO, 32'd12);
    check("post_reset_multu_HI", HI, 32'd0);

    // Randomized traffic honouring the stall contract.
    for (int i = 0; i < 1500; i++) begin
      logic        s, f;
      logic [2:0]  op;
      logic [31:0] a, b;
      s  = !m_inflight && ($urandom_range(0, 2) == 0);
      f  = ($urandom_range(0, 15) == 0);
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = '0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(0, 9)) - 32'd4;
        default: ;
      endcase
      step(s, op, a, b, f);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
